// File: rtl/core_sequencer.sv
// core_sequencer: fetch/wait/decode/exec/writeback controller driving the instruction port from a PC.
// Define PHILV_SEQ_PERF_EN to build the retired-instruction counter; otherwise retired reads zero.
module core_sequencer #(
    parameter int N           = 32,
    parameter int I_LENGTH    = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         run,
    input  logic         stall,
    output logic [N-1:0] mem_addr,
    output logic         mem_rd_en,
    input  logic [N-1:0] mem_rdata,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic [N-1:0] alu_result,
    output logic [4:0]   rd_addr,
    output logic [N-1:0] rd_data,
    output logic         rd_we,
    output logic [N-1:0] pc,
    output logic         halted,
    output logic [31:0]  retired
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
    localparam logic [N-1:0] PC_END = N'(I_LENGTH * 4);
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [6:0] OP_R = 7'b0110011;
    state_t state_q, state_d;
    logic [N-1:0] pc_q, pc_d, pc_inc, rd_data_q, rd_data_d;
    logic [31:0] instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic mem_rd_en_q, mem_rd_en_d, instr_valid_q, instr_valid_d;
    logic rd_we_q, rd_we_d, halted_q, halted_d;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        instr_d = instr_q;
        rd_data_d = rd_data_q;
        cnt_d = cnt_q;
        pc_inc = pc_q + N'(4);
        case (state_q)
            S_IDLE: state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                cnt_d = CW'(MEM_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    instr_d = 32'(mem_rdata);
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DECODE: state_d = instr_q == ECALL ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (!stall) begin
                    rd_data_d = alu_result;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d = pc_inc == PC_END ? '0 : pc_inc;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so they line up with the state they describe.
        mem_rd_en_d = state_d == S_FETCH;
        instr_valid_d = state_d == S_DECODE || state_d == S_EXEC || state_d == S_WB;
        rd_we_d = state_d == S_WB && instr_d[6:0] == OP_R && instr_d[11:7] != 5'd0;
        halted_d = state_d == S_HALT;
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            pc_q <= '0;
            instr_q <= '0;
            rd_data_q <= '0;
            cnt_q <= '0;
            mem_rd_en_q <= 1'b0;
            instr_valid_q <= 1'b0;
            rd_we_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            instr_q <= instr_d;
            rd_data_q <= rd_data_d;
            cnt_q <= cnt_d;
            mem_rd_en_q <= mem_rd_en_d;
            instr_valid_q <= instr_valid_d;
            rd_we_q <= rd_we_d;
            halted_q <= halted_d;
        end
    end
    assign mem_addr = {2'b00, pc_q[N-1:2]};
    assign mem_rd_en = mem_rd_en_q;
    assign instr = instr_q;
    assign instr_valid = instr_valid_q;
    assign rd_addr = instr_q[11:7];
    assign rd_data = rd_data_q;
    assign rd_we = rd_we_q;
    assign pc = pc_q;
    assign halted = halted_q;
`ifdef PHILV_SEQ_PERF_EN
    logic [31:0] retired_q, retired_d;
    always_comb begin
        retired_d = retired_q + 32'(state_q == S_WB);
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) retired_q <= '0;
        else retired_q <= retired_d;
    end
    assign retired = retired_q;
`else
    assign retired = '0;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed checks of core_sequencer (default build) plus a 4-word, 2-cycle-latency instance.
module tb_core_sequencer;
    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] ADD4  = 32'h00208233;
    localparam logic [31:0] ADD5  = 32'h002082B3;
    localparam logic [31:0] ADD6  = 32'h00208333;
    localparam logic [31:0] ADD0  = 32'h00208033;
    localparam logic [31:0] ADDI5 = 32'h00108293;
    localparam logic [31:0] ECALL = 32'h00000073;
`ifdef PHILV_SEQ_PERF_EN
    localparam logic [31:0] RET2 = 32'd2;
    localparam logic [31:0] RET5 = 32'd5;
`else
    localparam logic [31:0] RET2 = 32'd0;
    localparam logic [31:0] RET5 = 32'd0;
`endif
    logic clk = 1'b0, rstb = 1'b1, run = 1'b0, run2 = 1'b0, stall = 1'b0, stall2 = 1'b0;
    logic [31:0] alu = '0;
    logic [31:0] mem [0:7];
    logic [31:0] mem2 [0:3];
    logic [31:0] addr, rdata, instr, rd_data, pc, retired;
    logic [31:0] addr2, rdata2, instr2, rd_data2, pc2, retired2;
    logic [4:0] rd_addr, rd_addr2;
    logic rd_en, iv, rd_we, halted, rd_en2, iv2, rd_we2, halted2;
    int n_cmp = 0, n_err = 0;
    assign rdata = mem[addr[2:0]];
    assign rdata2 = mem2[addr2[1:0]];
    always #5 clk = ~clk;
    core_sequencer u_dut (
        .clk(clk), .rstb(rstb), .run(run), .stall(stall),
        .mem_addr(addr), .mem_rd_en(rd_en), .mem_rdata(rdata),
        .instr(instr), .instr_valid(iv), .alu_result(alu),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .pc(pc), .halted(halted), .retired(retired)
    );
    core_sequencer #(.N(32), .I_LENGTH(4), .MEM_LATENCY(2)) u_wrap (
        .clk(clk), .rstb(rstb), .run(run2), .stall(stall2),
        .mem_addr(addr2), .mem_rd_en(rd_en2), .mem_rdata(rdata2),
        .instr(instr2), .instr_valid(iv2), .alu_result(alu),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_we(rd_we2),
        .pc(pc2), .halted(halted2), .retired(retired2)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = ADD3; mem[1] = ECALL; mem[2] = ADD4; mem[3] = ADDI5; mem[4] = ADD3;
        mem2[0] = ADD3; mem2[1] = ADD4; mem2[2] = ADD5; mem2[3] = ADD6;
        #2 rstb = 1'b0;
        #1;
        check("rst_pc", pc, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_strobes", 32'({rd_en, rd_we, iv, halted}), 32'd0);
        check("rst_retired", retired, 32'd0);
        step(2);
        rstb = 1'b1; run = 1'b1;
        step(1);
        check("t1_fetch_rd_en", 32'(rd_en), 32'd1);
        check("t1_fetch_addr", addr, 32'd0);
        check("t1_fetch_iv", 32'(iv), 32'd0);
        step(1);
        check("t1_wait_rd_en", 32'(rd_en), 32'd0);
        step(1);
        check("t1_dec_instr", instr, ADD3);
        check("t1_dec_iv", 32'(iv), 32'd1);
        check("t1_dec_rd_addr", 32'(rd_addr), 32'd3);
        alu = 32'd5;
        step(1);
        check("t1_exec_rd_we", 32'(rd_we), 32'd0);
        step(1);
        check("t1_wb_rd_we", 32'(rd_we), 32'd1);
        check("t1_wb_rd_addr", 32'(rd_addr), 32'd3);
        check("t1_wb_rd_data", rd_data, 32'd5);
        check("t1_wb_pc", pc, 32'd0);
        step(1);
        check("t1_next_pc", pc, 32'd4);
        check("t1_next_addr", addr, 32'd1);
        check("t1_next_rd_we", 32'(rd_we), 32'd0);
        step(2);
        check("t2_dec_instr", instr, ECALL);
        check("t2_dec_iv", 32'(iv), 32'd1);
        step(1);
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_halt_pc", pc, 32'd4);
        check("t2_halt_iv", 32'(iv), 32'd0);
        run = 1'b0;
        step(3);
        check("t2_run0_halted", 32'(halted), 32'd1);
        check("t2_run0_rd_en", 32'(rd_en), 32'd0);
        run = 1'b1;
        step(3);
        check("t2_run1_halted", 32'(halted), 32'd1);
        check("t2_run1_pc", pc, 32'd4);
        check("t2_run1_strobes", 32'({rd_en, rd_we}), 32'd0);
        rstb = 1'b0;
        #1;
        check("t2_rst_pc", pc, 32'd0);
        check("t2_rst_halted", 32'(halted), 32'd0);
        mem[1] = ADD0;
        step(1);
        rstb = 1'b1;
        step(3);
        check("t3_dec_instr", instr, ADD3);
        stall = 1'b1; alu = 32'h0000_AAAA;
        step(1);
        check("t3_stall1_rd_we", 32'(rd_we), 32'd0);
        check("t3_stall1_iv", 32'(iv), 32'd1);
        alu = 32'h0000_1234;
        step(1);
        check("t3_stall2_rd_we", 32'(rd_we), 32'd0);
        step(1);
        check("t3_stall3_rd_we", 32'(rd_we), 32'd0);
        step(1);
        check("t3_stall4_rd_we", 32'(rd_we), 32'd0);
        check("t3_stall_rd_data", rd_data, 32'd0);
        stall = 1'b0; alu = 32'h0000_BEEF;
        step(1);
        check("t3_wb_rd_we", 32'(rd_we), 32'd1);
        check("t3_wb_rd_data", rd_data, 32'h0000_BEEF);
        stall = 1'b1;
        step(1);
        check("t3_ign_fetch_rd_en", 32'(rd_en), 32'd1);
        check("t3_ign_fetch_addr", addr, 32'd1);
        step(2);
        check("x0_dec_instr", instr, ADD0);
        check("x0_dec_rd_addr", 32'(rd_addr), 32'd0);
        stall = 1'b0; alu = 32'h77;
        step(2);
        check("x0_wb_rd_we", 32'(rd_we), 32'd0);
        check("x0_wb_iv", 32'(iv), 32'd1);
        check("x0_wb_rd_data", rd_data, 32'h77);
        step(1);
        check("t5_fetch_addr", addr, 32'd2);
        step(1);
        run = 1'b0;
        step(1);
        check("t5_dec_instr", instr, ADD4);
        step(2);
        check("t5_wb_rd_we", 32'(rd_we), 32'd1);
        check("t5_wb_rd_addr", 32'(rd_addr), 32'd4);
        step(1);
        check("t5_idle_pc", pc, 32'd12);
        check("t5_idle_strobes", 32'({rd_en, iv}), 32'd0);
        step(3);
        check("t5_idle_hold_rd_en", 32'(rd_en), 32'd0);
        check("t5_idle_hold_pc", pc, 32'd12);
        run = 1'b1;
        step(1);
        check("nop_fetch_addr", addr, 32'd3);
        step(2);
        check("nop_dec_instr", instr, ADDI5);
        step(2);
        check("nop_wb_rd_we", 32'(rd_we), 32'd0);
        check("nop_wb_iv", 32'(iv), 32'd1);
        step(1);
        check("nop_next_pc", pc, 32'd16);
        step(3);
        check("t6_exec_iv", 32'(iv), 32'd1);
        alu = 32'd9;
        rstb = 1'b0;
        #1;
        check("t6_rst_rd_we", 32'(rd_we), 32'd0);
        check("t6_rst_iv", 32'(iv), 32'd0);
        check("t6_rst_pc", pc, 32'd0);
        check("t6_rst_instr", instr, 32'd0);
        check("t6_rst_retired", retired, 32'd0);
        step(1);
        check("t6_rst_hold_rd_we", 32'(rd_we), 32'd0);
        rstb = 1'b1;
        step(5);
        check("t6_add1_rd_we", 32'(rd_we), 32'd1);
        check("t6_add1_rd_data", rd_data, 32'd9);
        step(5);
        check("t6_add2_rd_we", 32'(rd_we), 32'd0);
        run = 1'b0;
        step(1);
        check("t6_pc", pc, 32'd8);
        check("t6_retired", retired, RET2);
        run2 = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_pc_%0d", i), pc2, 32'((i % 4) * 4));
            check($sformatf("t4_addr_%0d", i), addr2, 32'(i % 4));
            check($sformatf("t4_rd_en_%0d", i), 32'(rd_en2), 32'd1);
            step(2);
            check($sformatf("t4_wait2_iv_%0d", i), 32'(iv2), 32'd0);
            step(1);
            check($sformatf("t4_dec_instr_%0d", i), instr2, mem2[i % 4]);
            step(2);
            check($sformatf("t4_wb_rd_addr_%0d", i), 32'(rd_we2 ? rd_addr2 : 5'd0), 32'(3 + i % 4));
            step(1);
        end
        check("t4_retired", retired2, RET5);
        run2 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
